csr_file: RTL and testbench
===========================

Name: csr_file

Overview:
- Machine-mode CSR register file. It is the responder/storage end of the CSR write/read interface driven by the interrupt controller, and of the CSR-instruction interface driven by ex.
- Holds mstatus, mie, mtvec, mscratch, mepc, mcause and a free-running 64-bit mcycle counter.
- Feeds the interrupt controller the live mtvec/mepc/mstatus values and the global interrupt enable.
- Sits beside the register file in the execute stage.

Parameters:
- MTVEC_RST, 32'h0000_0000, reset value of mtvec
- MSTATUS_RST, 32'h0000_1800, reset value of mstatus (MPP=2'b11, MIE=0, MPIE=0)

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ex_we_i  in  1  ex CSR write enable
- ex_waddr_i  in  32  ex CSR write address; bits [11:0] decoded, [31:12] ignored
- ex_raddr_i  in  32  ex CSR read address; bits [11:0] decoded
- ex_data_i  in  32  ex CSR write data
- ex_data_o  out  32  ex CSR read data (combinational)
- int_we_i  in  1  interrupt-controller CSR write enable
- int_waddr_i  in  32  interrupt-controller write address
- int_raddr_i  in  32  interrupt-controller read address
- int_data_i  in  32  interrupt-controller write data
- int_data_o  out  32  interrupt-controller read data (combinational)
- csr_mtvec_o  out  32  current mtvec
- csr_mepc_o  out  32  current mepc
- csr_mstatus_o  out  32  current mstatus
- global_int_en_o  out  1  mstatus[3]
- timer_int_o  out  1  timer interrupt pending (see Optional Feature)

Behaviour:
- Address map, 12-bit:
  - mstatus 0x300, mie 0x304, mtvec 0x305, mscratch 0x340, mepc 0x341, mcause 0x342
  - mcycle 0xB00, mcycleh 0xB80
  - cycle 0xC00, cycleh 0xC80: read-only aliases of mcycle/mcycleh; writes ignored
- Unmapped address: reads return 32'h0; writes are discarded with no side effect.
- Reset (rst=1 at a clk edge):
  - mstatus=MSTATUS_RST, mtvec=MTVEC_RST
  - mie, mscratch, mepc, mcause = 0; mcycle = 64'h0
  - Every output therefore reads its reset-derived value: csr_mtvec_o=MTVEC_RST, csr_mstatus_o=MSTATUS_RST, global_int_en_o=0, csr_mepc_o=0, timer_int_o=0, ex_data_o/int_data_o per address.
  - Reset mid-operation overrides any concurrent write.
- Writes:
  - Single write commit per cycle; write latency 1 (new value visible on csr_*_o the cycle after the edge).
  - Simultaneous writes: int_we_i wins over ex_we_i regardless of address, so exception entry/return is never lost. The losing ex write is dropped (ex is held while the interrupt controller sequences, so this is an error-path case only).
- Field rules:
  - mepc[1:0] forced to 2'b00 on write.
  - mcause stores all 32 bits.
  - mstatus stores all 32 bits.
  - mie stores all 32 bits.
- Reads:
  - Both read ports are fully combinational.
  - Bypass: if the winning write in this cycle targets the same 12-bit address as a read port, that port returns the write data (after field masking), not the stored value.
  - The bypass applies identically to csr_mtvec_o, csr_mepc_o and csr_mstatus_o, so the interrupt controller sees an mstatus written in the same cycle.
  - mcycle reads are not bypassed by the increment: a read returns the pre-increment value.
- mcycle:
  - Increments by 1 every cycle when not in reset; wraps from 64'hFFFF_FFFF_FFFF_FFFF to 0.
  - Write to 0xB00 loads the low 32 bits; write to 0xB80 loads the high 32 bits; the other half holds. The increment is suppressed in that cycle.
- global_int_en_o = effective mstatus[3] (with bypass).

Optional Feature:
- Macro: CSR_TIMER_EN
- Defined:
  - Adds a 64-bit mtimecmp at 0x7C0 (low) and 0x7C1 (high), R/W, reset 64'hFFFF_FFFF_FFFF_FFFF.
  - timer_int_o is registered, updated each cycle as (mcycle >= mtimecmp) & mie[7], unsigned 64-bit compare on the stored values. It therefore lags a compare-true condition by 1 cycle.
  - Writing mtimecmp clears the pending state the next cycle if the compare becomes false.
- Not defined:
  - 0x7C0/0x7C1 are unmapped; timer_int_o is tied to 0.

Test Plan:
- Reset, then read all mapped addresses -> mstatus=32'h1800, mtvec=0, other CSRs 0, global_int_en_o=0; mcycle reads N-1 on the Nth cycle after reset release.
- ex writes 0x305=32'h8000_0100, read next cycle -> csr_mtvec_o=32'h8000_0100; write to 0x341 with 32'h1003 -> mepc=32'h1000.
- Same cycle: int_we_i to 0x300 with 32'h1808 and ex_we_i to 0x340 with 32'hAA -> mstatus=32'h1808, mscratch unchanged 0, global_int_en_o=1.
- int writes 0x341=32'h200 while int_raddr_i=0x341 -> int_data_o=32'h200 in the same cycle; write to 0xC00 and to 0x123 -> no CSR changes, reads return count/0.
- Write mcycleh=32'hFFFF_FFFF and mcycle=32'hFFFF_FFFE on consecutive cycles -> mcycle wraps to 0 two cycles later and continues incrementing.
- CSR_TIMER_EN: mie=32'h80, mtimecmp=64'd50, mcycle=0 -> timer_int_o rises 1 cycle after mcycle reaches 50; mtimecmp set to 64'hFFFF_FFFF_FFFF_FFFF -> timer_int_o falls next cycle; with macro undefined -> timer_int_o stays 0.

Source files
------------

// File: rtl/csr_file_if.sv
// ---------------------------------------------------------------------------
// csr_file_if
// Bundles the two CSR access ports served by csr_file and the live CSR
// values it exports:
//   ex port   : ex_we_i, ex_waddr_i, ex_raddr_i, ex_data_i -> ex_data_o
//   int port  : int_we_i, int_waddr_i, int_raddr_i, int_data_i -> int_data_o
//   live CSRs : csr_mtvec_o, csr_mepc_o, csr_mstatus_o, global_int_en_o,
//               timer_int_o
// Modports: slave = csr_file (storage end), master = ex / interrupt
// controller side.
// ---------------------------------------------------------------------------
interface csr_file_if;
    logic        ex_we_i;
    logic [31:0] ex_waddr_i;
    logic [31:0] ex_raddr_i;
    logic [31:0] ex_data_i;
    logic [31:0] ex_data_o;

    logic        int_we_i;
    logic [31:0] int_waddr_i;
    logic [31:0] int_raddr_i;
    logic [31:0] int_data_i;
    logic [31:0] int_data_o;

    logic [31:0] csr_mtvec_o;
    logic [31:0] csr_mepc_o;
    logic [31:0] csr_mstatus_o;
    logic        global_int_en_o;
    logic        timer_int_o;

    modport slave (
        input  ex_we_i, ex_waddr_i, ex_raddr_i, ex_data_i,
        input  int_we_i, int_waddr_i, int_raddr_i, int_data_i,
        output ex_data_o, int_data_o,
        output csr_mtvec_o, csr_mepc_o, csr_mstatus_o,
        output global_int_en_o, timer_int_o
    );

    modport master (
        output ex_we_i, ex_waddr_i, ex_raddr_i, ex_data_i,
        output int_we_i, int_waddr_i, int_raddr_i, int_data_i,
        input  ex_data_o, int_data_o,
        input  csr_mtvec_o, csr_mepc_o, csr_mstatus_o,
        input  global_int_en_o, timer_int_o
    );
endinterface

// File: rtl/csr_file.sv
// ---------------------------------------------------------------------------
// csr_file
// Machine-mode CSR storage: mstatus, mie, mtvec, mscratch, mepc, mcause and
// a free-running 64-bit mcycle (read-only aliases cycle/cycleh).
// Ports:
//   clk  - system clock, all state changes on the rising edge
//   rst  - synchronous active-high reset
//   bus  - csr_file_if.slave: ex and interrupt-controller read/write ports,
//          live mtvec/mepc/mstatus, global interrupt enable, timer interrupt
// Build option: define CSR_TIMER_EN to add the 64-bit mtimecmp
// (0x7C0/0x7C1) and a registered timer interrupt; otherwise timer_int_o = 0.
// One write commits per cycle; the interrupt controller wins over ex.
// A write in flight is forwarded to read ports and live outputs that
// address the same CSR, so consumers never see a one-cycle-stale value.
// ---------------------------------------------------------------------------
module csr_file #(
    parameter logic [31:0] MTVEC_RST   = 32'h0000_0000,
    parameter logic [31:0] MSTATUS_RST = 32'h0000_1800
) (
    input  logic       clk,
    input  logic       rst,
    csr_file_if.slave  bus
);
    localparam logic [11:0] A_MSTATUS  = 12'h300;
    localparam logic [11:0] A_MIE      = 12'h304;
    localparam logic [11:0] A_MTVEC    = 12'h305;
    localparam logic [11:0] A_MSCRATCH = 12'h340;
    localparam logic [11:0] A_MEPC     = 12'h341;
    localparam logic [11:0] A_MCAUSE   = 12'h342;
    localparam logic [11:0] A_MCYCLE   = 12'hB00;
    localparam logic [11:0] A_MCYCLEH  = 12'hB80;
    localparam logic [11:0] A_CYCLE    = 12'hC00;
    localparam logic [11:0] A_CYCLEH   = 12'hC80;
`ifdef CSR_TIMER_EN
    localparam logic [11:0] A_MTCMP    = 12'h7C0;
    localparam logic [11:0] A_MTCMPH   = 12'h7C1;
`endif

    logic [31:0] r_mstatus;
    logic [31:0] r_mie;
    logic [31:0] r_mtvec;
    logic [31:0] r_mscratch;
    logic [31:0] r_mepc;
    logic [31:0] r_mcause;
    logic [63:0] r_mcycle;
`ifdef CSR_TIMER_EN
    logic [63:0] r_mtimecmp;
    logic        r_timer_int;
`endif

    // ---------------- write arbitration ----------------
    logic        w_wen;
    logic [11:0] w_waddr;
    logic [31:0] w_wdata_raw;
    logic [31:0] w_wdata;
    logic        w_wr_mapped;
    logic        w_wr_hit;

    assign w_wen       = bus.int_we_i | bus.ex_we_i;
    assign w_waddr     = bus.int_we_i ? bus.int_waddr_i[11:0] : bus.ex_waddr_i[11:0];
    assign w_wdata_raw = bus.int_we_i ? bus.int_data_i : bus.ex_data_i;
    // mepc is always word aligned; mask before storing and before forwarding.
    assign w_wdata     = (w_waddr == A_MEPC) ? {w_wdata_raw[31:2], 2'b00} : w_wdata_raw;

    // Only writable CSRs count as a hit; the cycle aliases and unmapped
    // addresses are neither stored nor forwarded.
    always_comb begin
        w_wr_mapped = 1'b0;
        case (w_waddr)
            A_MSTATUS, A_MIE, A_MTVEC, A_MSCRATCH, A_MEPC, A_MCAUSE,
            A_MCYCLE, A_MCYCLEH: w_wr_mapped = 1'b1;
`ifdef CSR_TIMER_EN
            A_MTCMP, A_MTCMPH:   w_wr_mapped = 1'b1;
`endif
            default:             w_wr_mapped = 1'b0;
        endcase
    end

    assign w_wr_hit = w_wen & w_wr_mapped;

    // Upper address bits are architecturally ignored.
    logic w_unused_addr;
    assign w_unused_addr = ^{bus.ex_waddr_i[31:12], bus.ex_raddr_i[31:12],
                             bus.int_waddr_i[31:12], bus.int_raddr_i[31:12]};

    // ---------------- read ports (0 = ex, 1 = int) ----------------
    logic [11:0] w_raddr [2];
    logic [31:0] w_rdata [2];

    assign w_raddr[0] = bus.ex_raddr_i[11:0];
    assign w_raddr[1] = bus.int_raddr_i[11:0];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_rd
            logic [31:0] w_stored;
            always_comb begin
                w_stored = 32'h0;
                case (w_raddr[gi])
                    A_MSTATUS:          w_stored = r_mstatus;
                    A_MIE:              w_stored = r_mie;
                    A_MTVEC:            w_stored = r_mtvec;
                    A_MSCRATCH:         w_stored = r_mscratch;
                    A_MEPC:             w_stored = r_mepc;
                    A_MCAUSE:           w_stored = r_mcause;
                    A_MCYCLE, A_CYCLE:  w_stored = r_mcycle[31:0];
                    A_MCYCLEH, A_CYCLEH: w_stored = r_mcycle[63:32];
`ifdef CSR_TIMER_EN
                    A_MTCMP:            w_stored = r_mtimecmp[31:0];
                    A_MTCMPH:           w_stored = r_mtimecmp[63:32];
`endif
                    default:            w_stored = 32'h0;
                endcase
            end
            assign w_rdata[gi] = (w_wr_hit && (w_waddr == w_raddr[gi])) ? w_wdata : w_stored;
        end
    endgenerate

    assign bus.ex_data_o  = w_rdata[0];
    assign bus.int_data_o = w_rdata[1];

    // ---------------- live CSR outputs (forwarded) ----------------
    logic [31:0] w_mstatus_eff;
    assign w_mstatus_eff       = (w_wr_hit && w_waddr == A_MSTATUS) ? w_wdata : r_mstatus;
    assign bus.csr_mstatus_o   = w_mstatus_eff;
    assign bus.csr_mtvec_o     = (w_wr_hit && w_waddr == A_MTVEC) ? w_wdata : r_mtvec;
    assign bus.csr_mepc_o      = (w_wr_hit && w_waddr == A_MEPC)  ? w_wdata : r_mepc;
    assign bus.global_int_en_o = w_mstatus_eff[3];

    // ---------------- state ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mstatus  <= MSTATUS_RST;
            r_mie      <= 32'h0;
            r_mtvec    <= MTVEC_RST;
            r_mscratch <= 32'h0;
            r_mepc     <= 32'h0;
            r_mcause   <= 32'h0;
            r_mcycle   <= 64'h0;
        end else begin
            if (w_wr_hit) begin
                case (w_waddr)
                    A_MSTATUS:  r_mstatus  <= w_wdata;
                    A_MIE:      r_mie      <= w_wdata;
                    A_MTVEC:    r_mtvec    <= w_wdata;
                    A_MSCRATCH: r_mscratch <= w_wdata;
                    A_MEPC:     r_mepc     <= w_wdata;
                    A_MCAUSE:   r_mcause   <= w_wdata;
                    default:    ;
                endcase
            end
            // A write to either mcycle half replaces that cycle's increment.
            if (w_wr_hit && w_waddr == A_MCYCLE)
                r_mcycle[31:0] <= w_wdata;
            else if (w_wr_hit && w_waddr == A_MCYCLEH)
                r_mcycle[63:32] <= w_wdata;
            else
                r_mcycle <= r_mcycle + 64'd1;
        end
    end

`ifdef CSR_TIMER_EN
    // Compare uses stored values, so the interrupt trails the compare by one
    // cycle and a new mtimecmp takes effect one cycle after it is written.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_mtimecmp  <= 64'hFFFF_FFFF_FFFF_FFFF;
            r_timer_int <= 1'b0;
        end else begin
            if (w_wr_hit && w_waddr == A_MTCMP)
                r_mtimecmp[31:0] <= w_wdata;
            if (w_wr_hit && w_waddr == A_MTCMPH)
                r_mtimecmp[63:32] <= w_wdata;
            r_timer_int <= (r_mcycle >= r_mtimecmp) & r_mie[7];
        end
    end
    assign bus.timer_int_o = r_timer_int;
`else
    assign bus.timer_int_o = 1'b0;
`endif

endmodule

// File: tb/tb_csr_file.sv
// ---------------------------------------------------------------------------
// tb_csr_file
// Directed test of csr_file: reset values, writes and field masking, write
// arbitration, same-cycle forwarding, cycle aliases, unmapped addresses,
// mcycle half loads and wrap, reset overriding a write, and the timer
// interrupt (CSR_TIMER_EN) or its absence.
// ---------------------------------------------------------------------------
module tb_csr_file;
    logic clk = 1'b0;
    logic rst;
    always #10 clk = ~clk;

    csr_file_if u_if ();

    csr_file #(
        .MTVEC_RST   (32'h0000_0000),
        .MSTATUS_RST (32'h0000_1800)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] exp_cyc;
    logic [31:0] lo_hold;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    // One clock: inputs set at a falling edge commit at the next rising edge.
    task automatic tick();
        @(negedge clk);
        exp_cyc = exp_cyc + 64'd1;
    endtask

    task automatic rd_ex(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        u_if.ex_raddr_i = addr;
        #1;
        check(tag, {32'h0, u_if.ex_data_o}, {32'h0, exp});
    endtask

    task automatic rd_int(input logic [31:0] addr, input logic [31:0] exp, input string tag);
        u_if.int_raddr_i = addr;
        #1;
        check(tag, {32'h0, u_if.int_data_o}, {32'h0, exp});
    endtask

    task automatic ex_wr(input logic [31:0] addr, input logic [31:0] data);
        u_if.ex_we_i    = 1'b1;
        u_if.ex_waddr_i = addr;
        u_if.ex_data_i  = data;
        tick();
        u_if.ex_we_i    = 1'b0;
    endtask

    initial begin
        rst              = 1'b1;
        exp_cyc          = 64'h0;
        u_if.ex_we_i     = 1'b0;
        u_if.ex_waddr_i  = 32'h0;
        u_if.ex_raddr_i  = 32'h0;
        u_if.ex_data_i   = 32'h0;
        u_if.int_we_i    = 1'b0;
        u_if.int_waddr_i = 32'h0;
        u_if.int_raddr_i = 32'h0;
        u_if.int_data_i  = 32'h0;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        #1;
        check("rst_mtvec",   {32'h0, u_if.csr_mtvec_o},   64'h0);
        check("rst_mstatus", {32'h0, u_if.csr_mstatus_o}, 64'h1800);
        check("rst_mepc",    {32'h0, u_if.csr_mepc_o},    64'h0);
        check("rst_gie",     {63'h0, u_if.global_int_en_o}, 64'h0);
        check("rst_timer",   {63'h0, u_if.timer_int_o},   64'h0);
        rd_ex (32'h300, 32'h1800, "rst_rd_mstatus");
        rd_ex (32'h304, 32'h0,    "rst_rd_mie");
        rd_ex (32'h305, 32'h0,    "rst_rd_mtvec");
        rd_ex (32'h340, 32'h0,    "rst_rd_mscratch");
        rd_int(32'h341, 32'h0,    "rst_rd_mepc");
        rd_int(32'h342, 32'h0,    "rst_rd_mcause");
        rd_int(32'hB80, 32'h0,    "rst_rd_mcycleh");
`ifdef CSR_TIMER_EN
        rd_int(32'h7C0, 32'hFFFF_FFFF, "rst_rd_mtimecmp");
`endif

        // ---------------- release, mcycle counts from 0 ----------------
        @(negedge clk);
        rst     = 1'b0;
        exp_cyc = 64'h0;
        rd_ex(32'hB00, 32'h0, "cyc_first");
        tick();
        rd_ex(32'hB00, 32'h1, "cyc_second");
        repeat (3) tick();
        rd_int(32'hC00, 32'h4, "cyc_alias_5th");
        rd_int(32'hC80, 32'h0, "cyc_alias_hi");

        // ---------------- mtvec, same-cycle forward then stored ----------------
        u_if.ex_we_i    = 1'b1;
        u_if.ex_waddr_i = 32'h305;
        u_if.ex_data_i  = 32'h8000_0100;
        #1;
        check("mtvec_fwd", {32'h0, u_if.csr_mtvec_o}, 64'h8000_0100);
        tick();
        u_if.ex_we_i = 1'b0;
        #1;
        check("mtvec_out", {32'h0, u_if.csr_mtvec_o}, 64'h8000_0100);
        rd_ex(32'h305, 32'h8000_0100, "mtvec_rd");

        // ---------------- mepc alignment ----------------
        ex_wr(32'h341, 32'h1003);
        #1;
        check("mepc_mask", {32'h0, u_if.csr_mepc_o}, 64'h1000);
        rd_int(32'h341, 32'h1000, "mepc_rd");

        // ---------------- simultaneous writes: int wins ----------------
        u_if.int_we_i    = 1'b1;
        u_if.int_waddr_i = 32'h300;
        u_if.int_data_i  = 32'h1808;
        u_if.ex_we_i     = 1'b1;
        u_if.ex_waddr_i  = 32'h340;
        u_if.ex_data_i   = 32'hAA;
        #1;
        check("gie_fwd",     {63'h0, u_if.global_int_en_o}, 64'h1);
        check("mstatus_fwd", {32'h0, u_if.csr_mstatus_o},   64'h1808);
        tick();
        u_if.int_we_i = 1'b0;
        u_if.ex_we_i  = 1'b0;
        #1;
        check("mstatus_out", {32'h0, u_if.csr_mstatus_o},   64'h1808);
        check("gie_out",     {63'h0, u_if.global_int_en_o}, 64'h1);
        rd_ex(32'h340, 32'h0, "mscratch_dropped");

        // ---------------- int write forwarded to both read ports ----------------
        u_if.int_we_i    = 1'b1;
        u_if.int_waddr_i = 32'h341;
        u_if.int_data_i  = 32'h200;
        rd_int(32'h341, 32'h200, "int_bypass");
        rd_ex (32'h341, 32'h200, "ex_bypass");
        check("mepc_fwd", {32'h0, u_if.csr_mepc_o}, 64'h200);
        tick();
        u_if.int_we_i = 1'b0;
        #1;
        check("mepc_out", {32'h0, u_if.csr_mepc_o}, 64'h200);

        // ---------------- read-only alias and unmapped writes ----------------
        ex_wr(32'hC00, 32'h55);
        rd_ex (32'hC00, exp_cyc[31:0], "cycle_ro");
        rd_int(32'hB00, exp_cyc[31:0], "mcycle_after_ro");
        ex_wr(32'h123, 32'hFFFF_FFFF);
        rd_ex(32'h123, 32'h0, "unmapped_rd");
        check("unmapped_mstatus", {32'h0, u_if.csr_mstatus_o}, 64'h1808);
        check("unmapped_mtvec",   {32'h0, u_if.csr_mtvec_o},   64'h8000_0100);
        check("unmapped_mepc",    {32'h0, u_if.csr_mepc_o},    64'h200);
`ifndef CSR_TIMER_EN
        ex_wr(32'h7C0, 32'h1234);
        rd_ex(32'h7C0, 32'h0, "mtimecmp_unmapped");
`endif

        // ---------------- remaining full-width CSRs ----------------
        ex_wr(32'h304, 32'hFFFF_FFFF);
        ex_wr(32'h342, 32'h8000_000B);
        ex_wr(32'h340, 32'hDEAD_BEEF);
        rd_ex (32'h304, 32'hFFFF_FFFF, "mie_rd");
        rd_int(32'h342, 32'h8000_000B, "mcause_rd");
        rd_ex (32'h340, 32'hDEAD_BEEF, "mscratch_rd");

        // ---------------- mcycle half loads and wrap ----------------
        lo_hold = exp_cyc[31:0];
        ex_wr(32'hB80, 32'hFFFF_FFFF);
        exp_cyc = {32'hFFFF_FFFF, lo_hold};
        u_if.ex_we_i    = 1'b1;
        u_if.ex_waddr_i = 32'hB00;
        u_if.ex_data_i  = 32'hFFFF_FFFE;
        rd_ex (32'hB80, 32'hFFFF_FFFF, "mcycleh_loaded");
        rd_int(32'hB00, 32'hFFFF_FFFE, "mcycle_bypass");
        tick();
        u_if.ex_we_i = 1'b0;
        exp_cyc = {32'hFFFF_FFFF, 32'hFFFF_FFFE};
        rd_ex (32'hB00, 32'hFFFF_FFFE, "mcycle_loaded");
        rd_int(32'hB80, 32'hFFFF_FFFF, "mcycleh_held");
        tick();
        rd_ex(32'hB00, 32'hFFFF_FFFF, "mcycle_max");
        tick();
        rd_ex (32'hB00, 32'h0, "mcycle_wrap_lo");
        rd_int(32'hB80, 32'h0, "mcycle_wrap_hi");
        tick();
        rd_ex(32'hC00, 32'h1, "mcycle_after_wrap");

        // ---------------- reset overrides a concurrent write ----------------
        u_if.ex_we_i    = 1'b1;
        u_if.ex_waddr_i = 32'h305;
        u_if.ex_data_i  = 32'h1234_5678;
        rst = 1'b1;
        tick();
        u_if.ex_we_i = 1'b0;
        #1;
        check("rst_wr_mtvec",   {32'h0, u_if.csr_mtvec_o},   64'h0);
        check("rst_wr_mstatus", {32'h0, u_if.csr_mstatus_o}, 64'h1800);
        rd_ex(32'hB00, 32'h0, "rst_wr_mcycle");
        rst     = 1'b0;
        exp_cyc = 64'h0;

        // ---------------- timer interrupt ----------------
`ifdef CSR_TIMER_EN
        ex_wr(32'h304, 32'h80);
        ex_wr(32'h7C1, 32'h0);
        ex_wr(32'h7C0, 32'd50);
        ex_wr(32'hB80, 32'h0);
        ex_wr(32'hB00, 32'h0);
        exp_cyc = 64'h0;
        #1;
        check("timer_idle", {63'h0, u_if.timer_int_o}, 64'h0);
        rd_ex(32'h7C0, 32'd50, "mtimecmp_rd");
        while (exp_cyc < 64'd52) begin
            tick();
            #1;
            // stored mcycle is exp_cyc; flag reflects mcycle-1 >= 50
            if (exp_cyc >= 64'd49)
                check("timer_edge", {63'h0, u_if.timer_int_o}, {63'h0, (exp_cyc >= 64'd51)});
        end
        ex_wr(32'h7C0, 32'hFFFF_FFFF);
        #1;
        check("timer_lag", {63'h0, u_if.timer_int_o}, 64'h1);
        ex_wr(32'h7C1, 32'hFFFF_FFFF);
        #1;
        check("timer_fall", {63'h0, u_if.timer_int_o}, 64'h0);
        tick();
        #1;
        check("timer_low", {63'h0, u_if.timer_int_o}, 64'h0);
`else
        ex_wr(32'h304, 32'h80);
        for (int k = 0; k < 4; k++) begin
            repeat (20) tick();
            #1;
            check("timer_tied", {63'h0, u_if.timer_int_o}, 64'h0);
        end
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
